// File: rtl/dp_pack16_seq.sv
`default_nettype none
// ============================================================================
// Module   : dp_pack16_seq
// Purpose  : Packs a valid/ready byte stream into halfwords and strobes them
//            (plus single constant fill loads) into a dp_regmx mux register.
// Revision : 1.0 - initial release
// ============================================================================
module dp_pack16_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             swap,
    input  logic             fill,
    input  logic [15:0]      fill_value,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [1:0]       select,
    output logic [15:0]      data0,
    output logic [15:0]      data1,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] hw_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] c_len_zero = '0;
    localparam logic [LEN_W-1:0] c_len_one  = LEN_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [LEN_W-1:0] r_len;
    logic             r_swap;
    logic [7:0]       r_first;
    logic [15:0]      r_data0;
    logic [15:0]      r_data1;
    logic             r_load_stb;
    logic             r_fill_stb;
    logic [LEN_W-1:0] r_hw_count;
    logic [LEN_W-1:0] w_hw_inc;
    logic             w_accept;

    assign w_hw_inc = r_hw_count + c_len_one;
    assign w_accept = byte_valid & byte_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // byte_ready is a pure function of state so upstream never sees a
    // combinational path from byte_valid back to byte_ready.
    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = (len == c_len_zero) ? S_DONE : S_LO;
                end
            end
            S_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    w_state_next = S_HI;
                end
            end
            S_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    w_state_next = (w_hw_inc == r_len) ? S_DONE : S_LO;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Fill is only honoured in IDLE without start, and load strobes only come
    // from HI, so the two strobe bits are mutually exclusive (select != 11).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len      <= '0;
            r_swap     <= 1'b0;
            r_first    <= '0;
            r_data0    <= '0;
            r_data1    <= '0;
            r_load_stb <= 1'b0;
            r_fill_stb <= 1'b0;
            r_hw_count <= '0;
        end else begin
            r_load_stb <= 1'b0;
            r_fill_stb <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len      <= len;
                        r_swap     <= swap;
                        r_hw_count <= '0;
                    end else if (fill) begin
                        r_data1    <= fill_value;
                        r_fill_stb <= 1'b1;
                    end
                end
                S_LO: begin
                    if (w_accept) begin
                        r_first <= byte_data;
                    end
                end
                S_HI: begin
                    if (w_accept) begin
                        r_data0    <= r_swap ? {byte_data, r_first} : {r_first, byte_data};
                        r_load_stb <= 1'b1;
                        r_hw_count <= w_hw_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign select   = {r_fill_stb, r_load_stb};
    assign data0    = r_data0;
    assign data1    = r_data1;
    assign hw_count = r_hw_count;

endmodule
`default_nettype wire

// File: tb/tb_dp_pack16_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_pack16_seq
// Purpose  : Directed self-checking bench for dp_pack16_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_pack16_seq;

    localparam int LEN_W = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             swap;
    logic             fill;
    logic [15:0]      fill_value;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;
    logic [1:0]       select;
    logic [15:0]      data0;
    logic [15:0]      data1;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] hw_count;

    int n_cmp  = 0;
    int n_fail = 0;

    dp_pack16_seq #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .swap       (swap),
        .fill       (fill),
        .fill_value (fill_value),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .select     (select),
        .data0      (data0),
        .data1      (data1),
        .busy       (busy),
        .done       (done),
        .hw_count   (hw_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control/status vector used by most checks: {select, done, busy, byte_ready}
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; len = '0; swap = 1'b0; fill = 1'b0;
        fill_value = '0; byte_data = '0; byte_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_cmp++;
        if ({select, done, busy, byte_ready} !== 5'b00_000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000_0", {select, done, busy, byte_ready});
        end
        n_cmp++;
        if ({data0, data1, hw_count} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {data0, data1, hw_count});
        end
    endtask

    task automatic test_pack(input logic sw, input logic [15:0] exp0, input logic [15:0] exp1);
        start = 1'b1; len = 8'd2; swap = sw;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({select, done, busy, byte_ready} !== 5'b00_011) begin
            n_fail++;
            $display("FAIL pack%0d_start: got %b expected 00011", sw, {select, done, busy, byte_ready});
        end
        byte_valid = 1'b1; byte_data = 8'h12; tick();
        byte_data = 8'h34; tick();
        n_cmp++;
        if ({select, done, data0} !== {2'b01, 1'b0, exp0}) begin
            n_fail++;
            $display("FAIL pack%0d_hw0: got %b/%b/%h expected 01/0/%h", sw, select, done, data0, exp0);
        end
        byte_data = 8'h56; tick();
        n_cmp++;
        if (select !== 2'b00) begin
            n_fail++;
            $display("FAIL pack%0d_gap: got select %b expected 00", sw, select);
        end
        byte_data = 8'h78; tick();
        n_cmp++;
        if ({select, done, busy, byte_ready, data0} !== {5'b01_110, exp1}) begin
            n_fail++;
            $display("FAIL pack%0d_hw1: got %b/%h expected 01110/%h", sw,
                     {select, done, busy, byte_ready}, data0, exp1);
        end
        byte_valid = 1'b0; tick();
        n_cmp++;
        if ({select, done, busy, byte_ready, hw_count} !== {5'b00_000, 8'd2}) begin
            n_fail++;
            $display("FAIL pack%0d_end: got %b/%h expected 00000/02", sw,
                     {select, done, busy, byte_ready}, hw_count);
        end
    endtask

    task automatic test_gaps();
        start = 1'b1; len = 8'd1; swap = 1'b0;
        tick();
        start = 1'b0;
        byte_valid = 1'b1; byte_data = 8'hAB; tick();
        byte_valid = 1'b0; byte_data = 8'hEE;
        for (int g = 0; g < 2; g++) begin
            tick();
            n_cmp++;
            if ({select, done, byte_ready} !== 4'b00_01) begin
                n_fail++;
                $display("FAIL gap%0d: got %b expected 0001", g, {select, done, byte_ready});
            end
        end
        byte_valid = 1'b1; byte_data = 8'hCD; tick();
        n_cmp++;
        if ({select, done, data0} !== {3'b01_1, 16'hABCD}) begin
            n_fail++;
            $display("FAIL gap_hw: got %b/%b/%h expected 01/1/abcd", select, done, data0);
        end
        byte_valid = 1'b0; tick();
        n_cmp++;
        if ({select, busy, hw_count} !== {3'b00_0, 8'd1}) begin
            n_fail++;
            $display("FAIL gap_end: got %b/%b/%h expected 00/0/01", select, busy, hw_count);
        end
    endtask

    task automatic test_fill();
        fill = 1'b1; fill_value = 16'hBEEF;
        tick();
        fill = 1'b0;
        n_cmp++;
        if ({select, busy, data1} !== {3'b10_0, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL fill_strobe: got %b/%b/%h expected 10/0/beef", select, busy, data1);
        end
        tick();
        n_cmp++;
        if ({select, data1} !== {2'b00, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL fill_hold: got %b/%h expected 00/beef", select, data1);
        end
        // start beats fill: the packet runs and data1 is never reloaded
        fill = 1'b1; fill_value = 16'h1111; start = 1'b1; len = 8'd1; swap = 1'b1;
        tick();
        fill = 1'b0; start = 1'b0;
        n_cmp++;
        if ({select, busy} !== 3'b00_1) begin
            n_fail++;
            $display("FAIL startfill_begin: got %b expected 001", {select, busy});
        end
        byte_valid = 1'b1; byte_data = 8'h5A; tick();
        byte_data = 8'hC3; tick();
        n_cmp++;
        if ({select, done, data0} !== {3'b01_1, 16'hC35A}) begin
            n_fail++;
            $display("FAIL startfill_hw: got %b/%b/%h expected 01/1/c35a", select, done, data0);
        end
        byte_valid = 1'b0; tick();
        n_cmp++;
        if ({select, busy, data1} !== {3'b00_0, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL startfill_end: got %b/%b/%h expected 00/0/beef", select, busy, data1);
        end
    endtask

    task automatic test_len_zero();
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({select, done, busy, byte_ready, hw_count} !== {5'b00_110, 8'd0}) begin
            n_fail++;
            $display("FAIL len0_done: got %b/%h expected 00110/00", {select, done, busy, byte_ready}, hw_count);
        end
        tick();
        n_cmp++;
        if ({select, done, busy} !== 4'b00_00) begin
            n_fail++;
            $display("FAIL len0_idle: got %b expected 0000", {select, done, busy});
        end
    endtask

    task automatic test_len_max();
        int strobes;
        strobes = 0;
        start = 1'b1; len = 8'd255; swap = 1'b0;
        tick();
        start = 1'b0;
        byte_valid = 1'b1;
        for (int k = 0; k < 255; k++) begin
            byte_data = 8'(2 * k); tick();
            byte_data = 8'(2 * k + 1); tick();
            if (select == 2'b01) strobes++;
            n_cmp++;
            if ({select, done, data0} !== {2'b01, (k == 254), 8'(2 * k), 8'(2 * k + 1)}) begin
                n_fail++;
                $display("FAIL lenmax_hw%0d: got %b/%b/%h expected 01/%0d/%h", k, select, done, data0,
                         (k == 254), {8'(2 * k), 8'(2 * k + 1)});
            end
        end
        byte_valid = 1'b0; tick();
        n_cmp++;
        if ({busy, hw_count} !== {1'b0, 8'hFF} || strobes != 255) begin
            n_fail++;
            $display("FAIL lenmax_end: got busy %b count %h strobes %0d expected 0/ff/255", busy, hw_count, strobes);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = 8'd2; swap = 1'b0;
        tick();
        start = 1'b0;
        byte_valid = 1'b1; byte_data = 8'h9A; tick();
        reset = 1'b1; byte_data = 8'hBC; tick();
        reset = 1'b0; byte_valid = 1'b0;
        n_cmp++;
        if ({select, done, busy, byte_ready, data0, data1, hw_count} !== {5'b00_000, 40'h0}) begin
            n_fail++;
            $display("FAIL midreset: got %b/%h/%h/%h expected 00000/0/0/0",
                     {select, done, busy, byte_ready}, data0, data1, hw_count);
        end
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        byte_valid = 1'b1; byte_data = 8'h11; tick();
        byte_data = 8'h22; tick();
        n_cmp++;
        if ({select, done, data0} !== {3'b01_1, 16'h1122}) begin
            n_fail++;
            $display("FAIL midreset_fresh: got %b/%b/%h expected 01/1/1122", select, done, data0);
        end
        byte_valid = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_pack(1'b0, 16'h1234, 16'h5678);
        test_pack(1'b1, 16'h3412, 16'h7856);
        test_gaps();
        test_fill();
        test_len_zero();
        test_len_max();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dp_pack16_seq.md
# dp_pack16_seq

Byte-to-halfword packing sequencer that drives a downstream 16-bit mux register of the dp_regmx family (select 01 loads input0, 10 loads input1, 00/11 hold). It accepts a byte stream over a valid/ready handshake, assembles consecutive byte pairs into halfwords, and issues a one-cycle load strobe per halfword. It also issues single fill loads of a programmable constant. It sits directly upstream of the register in the vector-unit datapath: `data0` feeds its `input0`, `data1` feeds its `input1`, and `select` feeds its `select`.

## Interface
Parameters:
- `LEN_W`, default 8: width of the halfword length and the halfword counter.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a packet of `len` halfwords; sampled only in IDLE.
- `len`  in  LEN_W  halfword count for the packet; latched with `start`.
- `swap`  in  1  byte order; latched with `start`. 0 = first byte to [15:8], 1 = first byte to [7:0].
- `fill`  in  1  request one load of `fill_value`; sampled only in IDLE.
- `fill_value`  in  16  constant to load on `fill`.
- `byte_data`  in  8  stream byte.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_ready`  out  1  block accepts a byte this cycle.
- `select`  out  2  register control: 01 load `data0`, 10 load `data1`, 00 hold.
- `data0`  out  16  assembled halfword.
- `data1`  out  16  registered fill value.
- `busy`  out  1  a packet is in progress.
- `done`  out  1  one-cycle pulse at packet completion.
- `hw_count`  out  LEN_W  halfwords issued in the current or most recent packet.

## Operation
- A byte is accepted on any cycle with `byte_valid & byte_ready`.
- States are IDLE, LO, HI and DONE.
- IDLE:
  - `byte_ready` = 0.
  - `start`: latch `len` and `swap`, clear `hw_count`, go to LO. If `len` = 0, go to DONE instead.
  - `fill` without `start`: register `fill_value` into `data1`; next cycle `select` = 10 for exactly one cycle; stay IDLE.
  - `start` and `fill` in the same cycle: `start` wins and `fill` is dropped.
- LO:
  - `byte_ready` = 1.
  - On accept, hold the byte in a first-byte register and go to HI.
- HI:
  - `byte_ready` = 1.
  - On accept, register into `data0` either {first, second} (swap = 0) or {second, first} (swap = 1).
  - Next cycle: `select` = 01 for exactly one cycle and `hw_count` increments.
  - Next state is DONE if `hw_count` + 1 == latched `len`, else LO.
- DONE:
  - `byte_ready` = 0, `done` = 1 for one cycle, then IDLE.
  - When the final halfword strobe is due, `select` = 01 coincides with `done` = 1.
- `busy` = 1 in LO, HI and DONE; 0 in IDLE.
- `start` or `fill` while not in IDLE is ignored and leaves no pending request.
- `select` never takes the value 11.
- `data0` and `data1` change only when loaded and hold their value otherwise.
- `hw_count` holds its final value in IDLE until the next `start`.
- Without `byte_valid`, LO and HI wait indefinitely.

## Timing
- Reset values: state IDLE, `select` = 00, `byte_ready` = 0, `busy` = 0, `done` = 0, `data0` = 0, `data1` = 0, `hw_count` = 0.
- Reset mid-packet aborts immediately:
  - no `select` strobe and no `done` pulse in the cycle after reset;
  - partially assembled byte discarded.
- Start latency: `start` sampled at cycle T; `byte_ready` = 1 at T+1.
- Halfword latency: second byte accepted at cycle C; `select` = 01 with valid `data0` at C+1; the downstream register shows the value at C+2.
- With `byte_valid` held high, throughput is one halfword per 2 cycles. `byte_ready` is asserted every cycle of the packet except DONE.
- `len` = 0: `start` at T gives `done` at T+1 and `busy` low again at T+2, with no `select` strobe.
- Fill: `fill` at T gives `select` = 10 with `data1` = `fill_value` at T+1.
- `byte_ready` depends only on state, never combinationally on `byte_valid`.

## Test plan
- Reset, then `start` with `len` = 2, `swap` = 0, bytes 12,34,56,78 with `byte_valid` held high -> `select` = 01 with `data0` = 1234, then 01 with `data0` = 5678 plus `done` = 1, then IDLE with `hw_count` = 2.
- Same stream with `swap` = 1 -> `data0` = 3412, then 7856.
- `byte_valid` toggled 1-0-0-1 between bytes, `len` = 1, bytes AB,CD -> exactly one strobe, `data0` = ABCD, no strobe during gaps, `done` coincident with the strobe.
- `fill` = 1, `fill_value` = BEEF in IDLE -> next cycle `select` = 10 with `data1` = BEEF. `start` and `fill` together -> packet starts and no 10 strobe ever appears.
- `len` = 0 -> `done` pulse 1 cycle after `start`, `select` stays 00. `len` = 255 -> 255 strobes, `hw_count` = FF, no wrap.
- Reset asserted in HI after the first byte -> next cycle all outputs at reset values; a new `start` packs a fresh pair correctly with no stale byte.
